// File: rtl/codec_i2c_writer.sv
// codec_i2c_writer: single-master I2C write of {DEV_ADDR, SubAddrL, data} to an audio codec.
// Ports:
//   I2C_clk  - clock, all logic on rising edge
//   reset    - synchronous active-high reset
//   write    - request one register write (sampled only when idle)
//   SubAddrL - register sub-address, captured with write
//   data     - register data, captured with write
//   SDA_in   - sampled SDA bus level for ACK detection
//   SCL      - I2C clock (1 = released)
//   SDA_out  - SDA drive value (always 0, open-drain)
//   SDA_oe   - 1 pulls SDA low, 0 releases it
//   busy     - frame in progress
//   NewCom   - one-cycle pulse at frame end, requests the next write
//   ack_err  - sticky NACK flag for the last frame
module codec_i2c_writer #(
    parameter logic [7:0]  DEV_ADDR = 8'h34,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic       I2C_clk,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] SubAddrL,
    input  logic [7:0] data,
    input  logic       SDA_in,
    output logic       SCL,
    output logic       SDA_out,
    output logic       SDA_oe,
    output logic       busy,
    output logic       NewCom,
    output logic       ack_err
);
    typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  qtr_q, qtr_d;
    logic [1:0]  ph_q, ph_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] sh_q, sh_d;
    logic        ack_err_d, scl_d, sda_oe_d, busy_d, new_com_d;
    logic        tick, ph_end;

    assign tick    = qtr_q == QMAX;
    assign ph_end  = tick && ph_q == 2'd3;
    assign SDA_out = 1'b0;

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        ack_err_d = ack_err;
        if (state_q == START || state_q == BIT || state_q == STOP) begin
            qtr_d = tick ? '0 : qtr_q + 8'd1;
            ph_d  = tick ? ph_q + 2'd1 : ph_q;
        end
        case (state_q)
            IDLE: begin
                if (write) begin
                    state_d   = START;
                    qtr_d     = '0;
                    ph_d      = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    sh_d      = {DEV_ADDR[7:1], 1'b0, SubAddrL, data};
                    ack_err_d = 1'b0;
                end
            end
            START: state_d = ph_end ? BIT : START;
            BIT: begin
                // ACK slot: sample on the last cycle SCL is high; the flag itself steers the byte decision
                if (tick && ph_q == 2'd2 && bit_q == 4'd8 && SDA_in)
                    ack_err_d = 1'b1;
                if (ph_end) begin
                    if (bit_q != 4'd8) begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = {sh_q[22:0], 1'b0};
                    end else if (ack_err || byte_q == 2'd2) begin
                        state_d = STOP;
                        bit_d   = '0;
                        byte_d  = '0;
                    end else begin
                        bit_d  = '0;
                        byte_d = byte_q + 2'd1;
                    end
                end
            end
            STOP:    state_d = ph_end ? DONE : STOP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus levels are decoded from next-state values so every output comes straight from a flop
    always_comb begin
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;
        case (state_d)
            START: begin
                scl_d    = ph_d != 2'd3;
                sda_oe_d = ph_d[1];
            end
            BIT: begin
                scl_d    = ph_d == 2'd1 || ph_d == 2'd2;
                sda_oe_d = bit_d != 4'd8 && !sh_d[23];
            end
            STOP: begin
                scl_d    = ph_d != 2'd0;
                sda_oe_d = !ph_d[1];
            end
            default: ;
        endcase
        busy_d    = state_d == START || state_d == BIT || state_d == STOP;
        new_com_d = state_d == DONE;
    end

    always_ff @(posedge I2C_clk) begin
        if (reset) begin
            state_q <= IDLE;
            qtr_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            SCL     <= 1'b1;
            SDA_oe  <= 1'b0;
            busy    <= 1'b0;
            NewCom  <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            SCL     <= scl_d;
            SDA_oe  <= sda_oe_d;
            busy    <= busy_d;
            NewCom  <= new_com_d;
            ack_err <= ack_err_d;
        end
    end
endmodule

// File: tb/tb_codec_i2c_writer.sv
// tb_codec_i2c_writer: checks codec_i2c_writer by decoding the I2C bus it produces.
module tb_codec_i2c_writer;
    logic       clk = 0, reset = 1, write = 0, SDA_in = 0;
    logic [7:0] SubAddrL = 0, data = 0;
    logic       SCL, SDA_out, SDA_oe, busy, NewCom, ack_err;
    int         errors = 0, checks = 0;
    int         nack_byte = 0;

    typedef struct packed {
        logic [23:0] bytes;
        logic [2:0]  rel;
        logic [1:0]  nbytes;
    } frame_t;

    typedef struct {
        logic [7:0] sub;
        logic [7:0] dat;
        int         nk;
        int         lat;
        logic       err;
        int         coll_at;
    } vec_t;

    frame_t fq[$];

    codec_i2c_writer #(.DEV_ADDR(8'h34), .CLK_DIV(4)) dut (
        .I2C_clk(clk),
        .reset(reset),
        .write(write),
        .SubAddrL(SubAddrL),
        .data(data),
        .SDA_in(SDA_in),
        .SCL(SCL),
        .SDA_out(SDA_out),
        .SDA_oe(SDA_oe),
        .busy(busy),
        .NewCom(NewCom),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: decodes START/STOP and bits on SCL rising edges, and plays the slave's ACK/NACK.
    logic scl_p = 1, sda_p = 1, in_frame = 0;
    int   pc = 0, skip = 0;
    logic bits [40];

    always @(negedge clk) begin
        logic   sda;
        frame_t f;
        sda = ~SDA_oe;
        chk("sda_out_zero", SDA_out, 0);
        if (reset) begin
            skip = 2;
            in_frame = 0;
            pc = 0;
        end else if (skip > 0) begin
            skip--;
        end else if (scl_p && SCL && sda != sda_p) begin
            if (!sda) begin
                chk("start_outside_frame", in_frame, 0);
                in_frame = 1;
                pc = 0;
            end else begin
                chk("stop_position", in_frame && pc % 9 == 1, 1);
                if (in_frame && pc % 9 == 1) begin
                    f.nbytes = 2'((pc - 1) / 9);
                    for (int b = 0; b < 3; b++) begin
                        for (int i = 0; i < 8; i++)
                            f.bytes[23 - 8 * b - i] = (b < int'(f.nbytes)) ? bits[9 * b + i] : 1'b0;
                        f.rel[2 - b] = (b < int'(f.nbytes)) ? bits[9 * b + 8] : 1'b1;
                    end
                    fq.push_back(f);
                end
                in_frame = 0;
            end
        end else if (!scl_p && SCL && in_frame && pc < 40) begin
            bits[pc] = sda;
            pc++;
        end
        scl_p = SCL;
        sda_p = sda;
        SDA_in = (in_frame && SCL && pc > 0 && pc % 9 == 0) ? (pc == 9 * nack_byte) : 1'($urandom);
    end

    function automatic int exp_latency(input int nk);
        return nk == 0 ? 116 * 4 : (8 + 36 * nk) * 4;
    endfunction

    task automatic run_write(input string name, input logic [7:0] sub, input logic [7:0] dat,
                             input int nk, input int exp_lat, input logic exp_err, input int coll_at);
        int          lat, nb;
        frame_t      f;
        logic [23:0] eb;
        @(posedge clk); #1;
        nack_byte = nk;
        SubAddrL = sub;
        data = dat;
        write = 1;
        @(posedge clk); #1;
        write = 0;
        chk($sformatf("%s_busy_accept", name), busy, 1);
        chk($sformatf("%s_ackerr_clear", name), ack_err, 0);
        lat = 0;
        while (!NewCom && lat < 600) begin
            @(posedge clk); #1;
            lat++;
            write = coll_at != 0 && lat == coll_at;
            SubAddrL = 8'($urandom);
            data = 8'($urandom);
        end
        chk($sformatf("%s_latency", name), lat, exp_lat);
        chk($sformatf("%s_busy_at_newcom", name), busy, 0);
        chk($sformatf("%s_ack_err", name), ack_err, exp_err);
        nb = nk == 0 ? 3 : nk;
        eb = {8'h34, sub, dat};
        for (int b = nb; b < 3; b++) eb[23 - 8 * b -: 8] = 8'h00;
        chk($sformatf("%s_frames", name), fq.size(), 1);
        if (fq.size() > 0) begin
            f = fq.pop_front();
            chk($sformatf("%s_nbytes", name), f.nbytes, nb);
            chk($sformatf("%s_bytes", name), f.bytes, eb);
            chk($sformatf("%s_ack_release", name), f.rel, 3'b111);
        end
        fq.delete();
        // a write coinciding with NewCom must be dropped
        write = 1;
        @(posedge clk); #1;
        write = 0;
        chk($sformatf("%s_newcom_width", name), NewCom, 0);
        chk($sformatf("%s_no_accept_in_done", name), busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk($sformatf("%s_idle_busy", name), busy, 0);
        chk($sformatf("%s_ack_err_sticky", name), ack_err, exp_err);
    endtask

    vec_t       vt[6];
    logic [7:0] ps[35], pd[35];

    initial begin
        int got, cyc, nk, saw;
        frame_t f;
        vt[0] = '{8'h0C, 8'h00, 0, 464, 1'b0, 0};
        vt[1] = '{8'h0C, 8'h00, 1, 176, 1'b1, 0};
        vt[2] = '{8'hA5, 8'h5A, 0, 464, 1'b0, 100};
        vt[3] = '{8'hFF, 8'h81, 2, 320, 1'b1, 100};
        vt[4] = '{8'h7E, 8'h01, 0, 464, 1'b0, 0};
        vt[5] = '{8'h00, 8'hFF, 3, 464, 1'b1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", SCL, 1);
        chk("rst_sda_oe", SDA_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_newcom", NewCom, 0);
        chk("rst_ack_err", ack_err, 0);
        reset = 0;

        for (int i = 0; i < 6; i++)
            run_write($sformatf("vec%0d", i), vt[i].sub, vt[i].dat, vt[i].nk, vt[i].lat, vt[i].err, vt[i].coll_at);

        // idle reset clears the sticky NACK flag left by the last vector
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("idle_reset_ack_err", ack_err, 0);

        // reset in mid-frame aborts without STOP or NewCom
        @(posedge clk); #1;
        nack_byte = 0;
        SubAddrL = 8'h40;
        data = 8'h41;
        write = 1;
        @(posedge clk); #1;
        write = 0;
        repeat (199) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_scl", SCL, 1);
        chk("abort_sda_oe", SDA_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_newcom", NewCom, 0);
        saw = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (NewCom || busy) saw = 1;
        end
        chk("abort_stays_idle", saw, 0);
        chk("abort_no_frame", fq.size(), 0);
        fq.delete();
        run_write("after_abort", 8'h1E, 8'hC3, 0, 464, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            nk = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            run_write($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), nk, exp_latency(nk), nk != 0, 0);
        end

        // producer loop: NewCom fetches the next write
        for (int i = 0; i < 35; i++) begin
            ps[i] = 8'($urandom);
            pd[i] = 8'($urandom);
        end
        @(posedge clk); #1;
        nack_byte = 0;
        SubAddrL = ps[0];
        data = pd[0];
        write = 1;
        got = 0;
        cyc = 0;
        while (got < 35 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (NewCom) begin
                got++;
                if (got < 35) begin
                    SubAddrL = ps[got];
                    data = pd[got];
                end else begin
                    write = 0;
                end
            end
        end
        write = 0;
        chk("prod_newcom_count", got, 35);
        chk("prod_frame_count", fq.size(), 35);
        for (int i = 0; i < 35 && fq.size() > 0; i++) begin
            f = fq.pop_front();
            chk($sformatf("prod_frame%0d", i), f.bytes, {8'h34, ps[i], pd[i]});
        end
        repeat (10) @(posedge clk);
        #1;
        chk("prod_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/codec_i2c_writer.md
CODEC_I2C_WRITER -- requirements
Module: codec_i2c_writer

Interface
REQ-001 Parameter DEV_ADDR, default 8'h34, is the codec 7-bit I2C address left-justified; bit 0 is ignored and always transmitted as 0 (write).
REQ-002 Parameter CLK_DIV, default 4, sets the I2C_clk cycles per SCL quarter-bit; legal values are 2..255.
REQ-003 I2C_clk  input  1  is the single clock; all logic is sampled on its rising edge.
REQ-004 reset  input  1  is synchronous and active-high.
REQ-005 write  input  1  requests one register write; it is sampled only while busy=0.
REQ-006 SubAddrL  input  8  is the codec register sub-address, captured with write.
REQ-007 data  input  8  is the codec register data, captured with write.
REQ-008 SDA_in  input  1  is the sampled SDA bus level, used for ACK detection.
REQ-009 SCL  output  1  is the I2C clock; 1 means released/high.
REQ-010 SDA_out  output  1  is the SDA drive value; it is always 0 when SDA_oe=1.
REQ-011 SDA_oe  output  1  drives the SDA bus low when 1; 0 releases SDA high.
REQ-012 busy  output  1  is high while a frame is in progress.
REQ-013 NewCom  output  1  is a one-cycle pulse at frame end, and requests the next write from the producer.
REQ-014 ack_err  output  1  flags a NACK in the last frame; it is sticky until the next accepted write.

Function
REQ-015 The FSM states SHALL be IDLE, START, BIT, STOP and DONE; a quarter counter (0..CLK_DIV-1), a phase counter (0..3), a bit counter (0..8) and a byte counter (0..2) SHALL sequence them.
REQ-016 Acceptance: in IDLE with write=1, the block SHALL capture {DEV_ADDR[7:1],0}, SubAddrL and data into a 24-bit shift register, clear ack_err, and enter START with busy=1 from the next cycle.
REQ-017 Any write asserted while busy=1 SHALL be ignored without side effects.
REQ-018 START phases: phases 0-1 drive SCL=1 with SDA released; phase 2 drives SCL=1 with SDA low; phase 3 drives SCL=0 with SDA low.
REQ-019 BIT phases: phase 0 drives SCL=0 and sets SDA; phases 1-2 drive SCL=1; phase 3 drives SCL=0. SDA SHALL change only in phase 0.
REQ-020 Bit order: bits 0-7 of each byte SHALL be sent MSB first (a 0 drives SDA low, a 1 releases it); bit 8 SHALL release SDA, and SDA_in sampled on the last cycle of phase 2 is the ACK (0=ACK).
REQ-021 STOP phases: phase 0 drives SCL=0 with SDA low; phase 1 drives SCL=1 with SDA low; phases 2-3 drive SCL=1 with SDA released.
REQ-022 NACK on any byte: the block SHALL set ack_err=1 and go directly to STOP after that bit 8; the remaining bytes SHALL NOT be sent.
REQ-023 DONE lasts one cycle: NewCom=1 and busy=0 in the same cycle, then the FSM returns to IDLE.
REQ-024 Latency without NACK: NewCom SHALL be high exactly 116*CLK_DIV cycles after the acceptance edge.
REQ-025 Latency with NACK on byte k (k=1..3): NewCom SHALL be high exactly (8+36k)*CLK_DIV cycles after the acceptance edge.
REQ-026 A write that is high in the same cycle as NewCom SHALL NOT be accepted; it is accepted from the following IDLE cycle.
REQ-027 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 When reset=1 the block SHALL force IDLE, SCL=1, SDA_oe=0, SDA_out=0, busy=0, NewCom=0, ack_err=0 and clear all counters and the shift register.
REQ-029 Reset mid-frame SHALL abort at the next edge: no STOP condition and no NewCom pulse are generated.
REQ-030 Reset SHALL take priority over a simultaneous write.

Verification (CLK_DIV=4, DEV_ADDR=8'h34)
REQ-031 Single write: write=1 with SubAddrL=8'h0C and data=8'h00, SDA_in held 0 -> bus decodes as START, 0x34, 0x0C, 0x00 with three ACKs, then STOP; NewCom pulses at cycle 464 and ack_err=0.
REQ-032 NACK on address: SDA_in=1 at the first ACK slot -> STOP follows; NewCom pulses at cycle 176 and ack_err=1.
REQ-033 Busy collision: a second write pulse at cycle 100 -> ignored; exactly one frame on the bus and one NewCom pulse.
REQ-034 Reset at cycle 200 of a frame -> the next cycle shows SCL=1, SDA_oe=0, busy=0 and no NewCom; a later write completes a normal frame.
REQ-035 Producer loop: NewCom is fed back to de_coder_produce for 35 writes -> 35 frames whose SubAddrL/data match the producer sequence in order, with no dropped or duplicated frame.
REQ-036 Bus protocol check (assertion): SDA SHALL change while SCL=1 only for START and STOP.
